// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a {sub_addr, data} register table after reset,
// issuing SCCB writes with optional read-back verify and programmable delays.
// Once idle, it arbitrates single host read/write requests onto the same
// CoreSCCB transaction port. All sequencing advances only on tick strobes.
module sccb_init_sequencer #(
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DELAY_UNIT = 100,
  parameter int unsigned TIMEOUT    = 1000,
  parameter logic [7:0]  RESET_REG  = 8'h12,
  parameter bit          VERIFY     = 1'b1,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              tick,
  input  logic              start_init,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [7:0]        host_sub_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_err,
  output logic              init_busy,
  output logic              init_done,
  output logic              verify_err,
  output logic [7:0]        err_count,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_id_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic [7:0]        sccb_data_out,
  input  logic              sccb_done
);

  // Delay counter holds up to 255 * DELAY_UNIT; timeout counter up to TIMEOUT.
  localparam int unsigned DLY_W = 8 + $clog2(DELAY_UNIT + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_WR     = 4'd3,
    ST_RD     = 4'd4,
    ST_DELAY  = 4'd5,
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_HOST   = 4'd8
  } state_t;

  // Error counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'h01);
  endfunction

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
  logic [7:0]        ent_sub_q, ent_sub_d;
  logic [7:0]        ent_data_q, ent_data_d;
  logic              hst_rw_q, hst_rw_d;
  logic [7:0]        hst_sub_q, hst_sub_d;
  logic [7:0]        hst_wdata_q, hst_wdata_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              init_busy_q, init_busy_d;
  logic              init_done_q, init_done_d;
  logic              verify_err_q, verify_err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              sccb_start_q, sccb_start_d;
  logic              sccb_rw_q, sccb_rw_d;
  logic [7:0]        sccb_id_q, sccb_id_d;
  logic [7:0]        sccb_sub_q, sccb_sub_d;
  logic [7:0]        sccb_din_q, sccb_din_d;
  logic              host_ack_q, host_ack_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic              host_err_q, host_err_d;

  // Next-state and output computation; only host_ack and the pending flag
  // change off-tick, everything else waits for a tick strobe.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | start_init;
    tbl_addr_d   = tbl_addr_q;
    ent_sub_d    = ent_sub_q;
    ent_data_d   = ent_data_q;
    hst_rw_d     = hst_rw_q;
    hst_sub_d    = hst_sub_q;
    hst_wdata_d  = hst_wdata_q;
    dly_d        = dly_q;
    tmo_d        = tmo_q;
    init_busy_d  = init_busy_q;
    init_done_d  = init_done_q;
    verify_err_d = verify_err_q;
    err_count_d  = err_count_q;
    sccb_start_d = sccb_start_q;
    sccb_rw_d    = sccb_rw_q;
    sccb_id_d    = sccb_id_q;
    sccb_sub_d   = sccb_sub_q;
    sccb_din_d   = sccb_din_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_err_d   = host_err_q;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            // A start_init arriving on this same edge is kept for a rerun.
            state_d      = ST_FETCH;
            pend_d       = start_init;
            tbl_addr_d   = '0;
            err_count_d  = 8'h00;
            verify_err_d = 1'b0;
            init_done_d  = 1'b0;
            init_busy_d  = 1'b1;
          end else if (host_req) begin
            state_d     = ST_HOST;
            hst_rw_d    = host_rw;
            hst_sub_d   = host_sub_addr;
            hst_wdata_d = host_wdata;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FETCH: begin
          state_d = ST_DECODE;
        end

        ST_DECODE: begin
          ent_sub_d  = tbl_data[15:8];
          ent_data_d = tbl_data[7:0];
          if (tbl_data == 16'hFFFF) begin
            state_d = ST_DONE;
          end else if (tbl_data[15:8] == 8'hFF) begin
            if (tbl_data[7:0] == 8'h00) begin
              state_d = ST_NEXT;
            end else begin
              state_d = ST_DELAY;
              dly_d   = DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
            end
          end else begin
            state_d = ST_WR;
          end
        end

        ST_WR: begin
          if (!sccb_start_q) begin
            // Launch tick; start was low on the previous tick by construction.
            sccb_start_d = 1'b1;
            sccb_rw_d    = 1'b0;
            sccb_id_d    = DEV_ID;
            sccb_sub_d   = ent_sub_q;
            sccb_din_d   = ent_data_q;
            tmo_d        = '0;
          end else if (sccb_done) begin
            sccb_start_d = 1'b0;
            if (VERIFY && (ent_sub_q != RESET_REG)) begin
              state_d = ST_RD;
            end else begin
              state_d = ST_NEXT;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Timed-out write: no read-back, move on to the next entry.
            sccb_start_d = 1'b0;
            verify_err_d = 1'b1;
            err_count_d  = sat_inc(err_count_q);
            state_d      = ST_NEXT;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        ST_RD: begin
          if (!sccb_start_q) begin
            sccb_start_d = 1'b1;
            sccb_rw_d    = 1'b1;
            sccb_id_d    = DEV_ID | 8'h01;
            sccb_sub_d   = ent_sub_q;
            tmo_d        = '0;
          end else if (sccb_done) begin
            sccb_start_d = 1'b0;
            state_d      = ST_NEXT;
            if (sccb_data_out != ent_data_q) begin
              verify_err_d = 1'b1;
              err_count_d  = sat_inc(err_count_q);
            end else begin
              verify_err_d = verify_err_q;
            end
          end else if (tmo_q == TMO_LAST) begin
            sccb_start_d = 1'b0;
            verify_err_d = 1'b1;
            err_count_d  = sat_inc(err_count_q);
            state_d      = ST_NEXT;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        ST_DELAY: begin
          // Leaves on the tick that brings the count to zero, so the state
          // lasts exactly data*DELAY_UNIT ticks.
          if ((dly_q == DLY_ONE) || (dly_q == '0)) begin
            dly_d   = '0;
            state_d = ST_NEXT;
          end else begin
            dly_d = dly_q - DLY_ONE;
          end
        end

        ST_NEXT: begin
          if (&tbl_addr_q) begin
            state_d = ST_DONE;
          end else begin
            tbl_addr_d = tbl_addr_q + ADDR_W'(1);
            state_d    = ST_FETCH;
          end
        end

        ST_DONE: begin
          init_busy_d = 1'b0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end

        ST_HOST: begin
          if (!sccb_start_q) begin
            sccb_start_d = 1'b1;
            sccb_rw_d    = hst_rw_q;
            sccb_id_d    = DEV_ID | {7'b0000000, hst_rw_q};
            sccb_sub_d   = hst_sub_q;
            sccb_din_d   = hst_wdata_q;
            tmo_d        = '0;
          end else if (sccb_done) begin
            sccb_start_d = 1'b0;
            host_ack_d   = 1'b1;
            host_err_d   = 1'b0;
            host_rdata_d = hst_rw_q ? sccb_data_out : 8'h00;
            state_d      = ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            sccb_start_d = 1'b0;
            host_ack_d   = 1'b1;
            host_err_d   = 1'b1;
            host_rdata_d = 8'h00;
            state_d      = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        default: begin
          sccb_start_d = 1'b0;
          state_d      = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q      <= ST_IDLE;
      pend_q       <= AUTO_START;
      tbl_addr_q   <= '0;
      ent_sub_q    <= 8'h00;
      ent_data_q   <= 8'h00;
      hst_rw_q     <= 1'b0;
      hst_sub_q    <= 8'h00;
      hst_wdata_q  <= 8'h00;
      dly_q        <= '0;
      tmo_q        <= '0;
      init_busy_q  <= 1'b0;
      init_done_q  <= 1'b0;
      verify_err_q <= 1'b0;
      err_count_q  <= 8'h00;
      sccb_start_q <= 1'b0;
      sccb_rw_q    <= 1'b0;
      sccb_id_q    <= 8'h00;
      sccb_sub_q   <= 8'h00;
      sccb_din_q   <= 8'h00;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      host_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      tbl_addr_q   <= tbl_addr_d;
      ent_sub_q    <= ent_sub_d;
      ent_data_q   <= ent_data_d;
      hst_rw_q     <= hst_rw_d;
      hst_sub_q    <= hst_sub_d;
      hst_wdata_q  <= hst_wdata_d;
      dly_q        <= dly_d;
      tmo_q        <= tmo_d;
      init_busy_q  <= init_busy_d;
      init_done_q  <= init_done_d;
      verify_err_q <= verify_err_d;
      err_count_q  <= err_count_d;
      sccb_start_q <= sccb_start_d;
      sccb_rw_q    <= sccb_rw_d;
      sccb_id_q    <= sccb_id_d;
      sccb_sub_q   <= sccb_sub_d;
      sccb_din_q   <= sccb_din_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      host_err_q   <= host_err_d;
    end
  end

  assign tbl_addr      = tbl_addr_q;
  assign host_ack      = host_ack_q;
  assign host_rdata    = host_rdata_q;
  assign host_err      = host_err_q;
  assign init_busy     = init_busy_q;
  assign init_done     = init_done_q;
  assign verify_err    = verify_err_q;
  assign err_count     = err_count_q;
  assign sccb_start    = sccb_start_q;
  assign sccb_rw       = sccb_rw_q;
  assign sccb_id_addr  = sccb_id_q;
  assign sccb_sub_addr = sccb_sub_q;
  assign sccb_data_in  = sccb_din_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Testbench for sccb_init_sequencer: sync ROM, behavioural CoreSCCB model
// that logs every transaction, scenario table plus directed corner cases.
module tb_sccb_init_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        tick = 1'b0;
  logic [1:0]  tdiv = 2'd0;
  logic        start_init;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = 16'hFFFF;
  logic        host_req, host_rw;
  logic [7:0]  host_sub_addr, host_wdata;
  logic        host_ack, host_err;
  logic [7:0]  host_rdata;
  logic        init_busy, init_done, verify_err;
  logic [7:0]  err_count;
  logic        sccb_start, sccb_rw;
  logic [7:0]  sccb_id_addr, sccb_sub_addr, sccb_data_in;
  logic [7:0]  sccb_data_out;
  logic        sccb_done;

  logic        corrupt_mode, hang_mode;
  logic [15:0] rom [256];

  typedef struct {
    logic       rw;
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] din;
    int         hi;   // ticks with start high
    int         gap;  // ticks with start low before this transaction
  } txn_t;
  txn_t txq[$];

  typedef struct {
    logic       corrupt;
    logic       hang;
    logic [7:0] dly;
    logic       exp_verr;
    logic [7:0] exp_err;
    int         exp_gap;
    int         exp_hi0;
  } scen_t;
  scen_t sc[4];

  int n_cmp = 0;
  int n_bad = 0;

  sccb_init_sequencer dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .tick(tick), .start_init(start_init),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_req(host_req), .host_rw(host_rw), .host_sub_addr(host_sub_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_err(host_err), .init_busy(init_busy), .init_done(init_done),
    .verify_err(verify_err), .err_count(err_count),
    .sccb_start(sccb_start), .sccb_rw(sccb_rw), .sccb_id_addr(sccb_id_addr),
    .sccb_sub_addr(sccb_sub_addr), .sccb_data_in(sccb_data_in),
    .sccb_data_out(sccb_data_out), .sccb_done(sccb_done)
  );

  always #5 PCLK = ~PCLK;

  // One-PCLK tick every fourth cycle, changed on the falling edge.
  always @(negedge PCLK) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  // Synchronous table ROM, one PCLK latency.
  always @(posedge PCLK) tbl_data <= rom[tbl_addr];

  // CoreSCCB model: done three ticks into a transaction, held until start drops.
  initial begin : sccb_model
    logic [7:0] mem [256];
    txn_t cur;
    logic in_tx;
    int   hi_cnt, lo_cnt;
    in_tx = 1'b0; hi_cnt = 0; lo_cnt = 0;
    cur = '{rw: 1'b0, id: 8'h00, sub: 8'h00, din: 8'h00, hi: 0, gap: 0};
    sccb_done = 1'b0;
    sccb_data_out = 8'h00;
    forever begin
      @(posedge PCLK);
      if (sccb_start) begin
        if (tick) begin
          if (!in_tx) begin
            in_tx   = 1'b1;
            cur.rw  = sccb_rw;
            cur.id  = sccb_id_addr;
            cur.sub = sccb_sub_addr;
            cur.din = sccb_data_in;
            cur.gap = lo_cnt;
            hi_cnt  = 0;
          end
          hi_cnt = hi_cnt + 1;
          if (hi_cnt == 3 && !(hang_mode && !cur.rw && cur.sub == 8'h12)) begin
            sccb_done <= 1'b1;
            if (cur.rw) begin
              if (cur.sub == 8'h0A)
                sccb_data_out <= 8'h76;
              else if (corrupt_mode && cur.sub == 8'h11)
                sccb_data_out <= 8'h00;
              else
                sccb_data_out <= mem[cur.sub];
            end else begin
              mem[cur.sub] = cur.din;
            end
          end
        end
      end else begin
        sccb_done <= 1'b0;
        if (in_tx) begin
          cur.hi = hi_cnt;
          txq.push_back(cur);
          in_tx  = 1'b0;
          lo_cnt = 0;
        end
        if (tick) lo_cnt = lo_cnt + 1;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // sel: 0 busy, 1 run complete, 2 host_ack, 3 sccb_start
  task automatic wait_cond(input int sel, input int maxc, input string nm);
    int  n;
    bit  hit;
    n = 0; hit = 1'b0;
    while (!hit && n < maxc) begin
      @(posedge PCLK); #1;
      n++;
      case (sel)
        0: hit = init_busy;
        1: hit = init_done && !init_busy;
        2: hit = host_ack;
        3: hit = sccb_start;
        default: hit = 1'b1;
      endcase
    end
    chk({"wait_", nm}, 32'(hit), 32'd1);
  endtask

  task automatic chk_txn(input string nm, input int idx, input logic rw,
                         input logic [7:0] id, input logic [7:0] sub);
    chk({nm, "_present"}, 32'(idx < txq.size()), 32'd1);
    if (idx < txq.size()) begin
      chk({nm, "_rw"},  32'(txq[idx].rw),  32'(rw));
      chk({nm, "_id"},  32'(txq[idx].id),  32'(id));
      chk({nm, "_sub"}, 32'(txq[idx].sub), 32'(sub));
    end
  endtask

  task automatic pulse_start();
    @(posedge PCLK iff tick);
    @(negedge PCLK); start_init = 1'b1;
    @(negedge PCLK); start_init = 1'b0;
  endtask

  initial begin : main
    int base;
    int n;
    // corrupt, hang, delay byte, verify_err, err_count, low ticks W12->W11, hi ticks of W12.
    // Gap = NEXT,FETCH,DECODE of the delay entry + delay ticks + NEXT,FETCH,DECODE,launch.
    sc[0] = '{corrupt: 1'b0, hang: 1'b0, dly: 8'h01, exp_verr: 1'b0, exp_err: 8'd0, exp_gap: 107, exp_hi0: 4};
    sc[1] = '{corrupt: 1'b1, hang: 1'b0, dly: 8'h01, exp_verr: 1'b1, exp_err: 8'd1, exp_gap: 107, exp_hi0: 4};
    sc[2] = '{corrupt: 1'b0, hang: 1'b1, dly: 8'h01, exp_verr: 1'b1, exp_err: 8'd1, exp_gap: 107, exp_hi0: 1000};
    sc[3] = '{corrupt: 1'b0, hang: 1'b0, dly: 8'h00, exp_verr: 1'b0, exp_err: 8'd0, exp_gap: 7,   exp_hi0: 4};

    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'hFF01; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    corrupt_mode = 1'b0; hang_mode = 1'b0;
    start_init = 1'b0; host_req = 1'b0; host_rw = 1'b0;
    host_sub_addr = 8'h00; host_wdata = 8'h00;
    PRESETN = 1'b1;
    #2 PRESETN = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_start", 32'(sccb_start), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_id", 32'(sccb_id_addr), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    @(negedge PCLK) PRESETN = 1'b1;

    // Scenario table; scenario 0 is the automatic run out of reset.
    for (int i = 0; i < 4; i++) begin
      corrupt_mode = sc[i].corrupt;
      hang_mode    = sc[i].hang;
      rom[1]       = {8'hFF, sc[i].dly};
      base         = txq.size();
      if (i != 0) pulse_start();
      wait_cond(0, 200, $sformatf("busy%0d", i));
      chk($sformatf("s%0d_done_cleared", i), 32'(init_done), 32'd0);
      chk($sformatf("s%0d_verr_cleared", i), 32'(verify_err), 32'd0);
      wait_cond(1, 8000, $sformatf("done%0d", i));
      chk($sformatf("s%0d_verify_err", i), 32'(verify_err), 32'(sc[i].exp_verr));
      chk($sformatf("s%0d_err_count", i), 32'(err_count), 32'(sc[i].exp_err));
      chk($sformatf("s%0d_ntx", i), 32'(txq.size() - base), 32'd3);
      chk_txn($sformatf("s%0d_t0", i), base, 1'b0, 8'h42, 8'h12);
      chk_txn($sformatf("s%0d_t1", i), base + 1, 1'b0, 8'h42, 8'h11);
      chk_txn($sformatf("s%0d_t2", i), base + 2, 1'b1, 8'h43, 8'h11);
      if (txq.size() >= base + 3) begin
        chk($sformatf("s%0d_t0_data", i), 32'(txq[base].din), 32'h80);
        chk($sformatf("s%0d_t0_hi", i), 32'(txq[base].hi), 32'(sc[i].exp_hi0));
        chk($sformatf("s%0d_t1_data", i), 32'(txq[base+1].din), 32'h01);
        chk($sformatf("s%0d_gap_delay", i), 32'(txq[base+1].gap), 32'(sc[i].exp_gap));
        chk($sformatf("s%0d_gap_rd", i), 32'(txq[base+2].gap), 32'd1);
      end
    end
    corrupt_mode = 1'b0; hang_mode = 1'b0; rom[1] = 16'hFF01;

    // Host read requested during the delay entry is held off until DONE.
    base = txq.size();
    pulse_start();
    n = 0;
    while (txq.size() <= base && n < 500) begin @(posedge PCLK); n++; end
    chk("hdly_first_write_seen", 32'(txq.size() > base), 32'd1);
    @(negedge PCLK);
    host_req = 1'b1; host_rw = 1'b1; host_sub_addr = 8'h0A; host_wdata = 8'h00;
    wait_cond(1, 2000, "hdly_done");
    chk("hdly_held_off", 32'(txq.size() - base), 32'd3);
    wait_cond(2, 400, "hdly_ack");
    host_req = 1'b0;
    chk("hdly_rdata", 32'(host_rdata), 32'h76);
    chk("hdly_err", 32'(host_err), 32'd0);
    @(posedge PCLK); #1;
    chk("hdly_ack_width", 32'(host_ack), 32'd0);
    repeat (80) @(posedge PCLK);
    chk("hdly_ntx", 32'(txq.size() - base), 32'd4);
    chk_txn("hdly_txn", base + 3, 1'b1, 8'h43, 8'h0A);

    // Reset asserted mid-write; run restarts from address 0 afterwards.
    pulse_start();
    wait_cond(3, 400, "rstwr_start");
    @(negedge PCLK); #2 PRESETN = 1'b0;
    #1;
    chk("rstwr_start_low", 32'(sccb_start), 32'd0);
    chk("rstwr_busy", 32'(init_busy), 32'd0);
    chk("rstwr_id", 32'(sccb_id_addr), 32'd0);
    chk("rstwr_sub", 32'(sccb_sub_addr), 32'd0);
    chk("rstwr_din", 32'(sccb_data_in), 32'd0);
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    base = txq.size();
    #1;
    chk("rstwr_addr0", 32'(tbl_addr), 32'd0);
    wait_cond(1, 2000, "rstwr_done");
    chk("rstwr_ntx", 32'(txq.size() - base), 32'd3);
    chk_txn("rstwr_t0", base, 1'b0, 8'h42, 8'h12);

    // start_init between ticks plus a host write in IDLE on the same tick.
    base = txq.size();
    @(posedge PCLK iff tick);
    @(negedge PCLK);
    start_init = 1'b1; host_req = 1'b1; host_rw = 1'b0;
    host_sub_addr = 8'h33; host_wdata = 8'h5A;
    @(negedge PCLK); start_init = 1'b0;
    wait_cond(0, 200, "arb_busy");
    wait_cond(1, 2000, "arb_done");
    chk("arb_table_first", 32'(txq.size() - base), 32'd3);
    chk_txn("arb_t0", base, 1'b0, 8'h42, 8'h12);
    wait_cond(2, 400, "arb_ack");
    host_req = 1'b0;
    chk("arb_rdata", 32'(host_rdata), 32'h00);
    chk("arb_err", 32'(host_err), 32'd0);
    repeat (80) @(posedge PCLK);
    chk("arb_ntx", 32'(txq.size() - base), 32'd4);
    chk_txn("arb_host", base + 3, 1'b0, 8'h42, 8'h33);
    if (txq.size() >= base + 4) chk("arb_host_data", 32'(txq[base+3].din), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
Table-driven sequencer that owns the CoreSCCB transaction port and configures the camera after reset. It walks a register table of {sub_addr, data} entries, issuing SCCB writes with optional read-back verify and inserting programmable delays. When the table is finished, it arbitrates single host read/write requests onto the same SCCB engine. It sits between the clock_divider/CoreSCCB pair and the APB register wrapper, replacing the hard-coded bring-up FSM.

Parameters:
DEV_ID, 8'h42, SCCB write ID; reads use DEV_ID|8'h01
ADDR_W, 8, table address width
DELAY_UNIT, 100, ticks per delay-entry unit (100 ticks at 100 kHz = 1 ms)
TIMEOUT, 1000, ticks to wait for sccb_done before aborting a transaction
RESET_REG, 8'h12, sub-address whose writes are never verified (soft reset)
VERIFY, 1, 1 = read back and compare every table write
AUTO_START, 1, 1 = table run is pending out of reset

Ports:
PCLK  in  1  system clock
PRESETN  in  1  async active-low reset
tick  in  1  one-PCLK strobe from clock_divider mid_pulse; FSM advances only when tick=1
start_init  in  1  PCLK pulse; requests a table run
tbl_addr  out  ADDR_W  table ROM address
tbl_data  in  16  {sub_addr[15:8], data[7:0]}, sync ROM, 1 PCLK latency
host_req  in  1  level; host transaction request
host_rw  in  1  0 = write, 1 = read
host_sub_addr  in  8  host register address
host_wdata  in  8  host write data
host_ack  out  1  one-PCLK pulse at host transaction end
host_rdata  out  8  read data, valid with host_ack
host_err  out  1  valid with host_ack; 1 = timed out
init_busy  out  1  table run in progress
init_done  out  1  table run complete (sticky until next run)
verify_err  out  1  sticky; any verify mismatch or timeout in the current run
err_count  out  8  saturating error count for the current run
sccb_start  out  1  to CoreSCCB start
sccb_rw  out  1  to CoreSCCB rw
sccb_id_addr  out  8  to CoreSCCB id_addr
sccb_sub_addr  out  8  to CoreSCCB sub_addr
sccb_data_in  out  8  to CoreSCCB data_in
sccb_data_out  in  8  from CoreSCCB data_out
sccb_done  in  1  from CoreSCCB done

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, delay and timeout counters 0. Pending run flag = AUTO_START.
- start_init sets the pending flag on any PCLK edge. The flag clears when the run begins.
- All FSM transitions occur only on PCLK edges with tick=1. host_ack is the only output that pulses independently of tick; it clears on the next PCLK.
- States:
  - IDLE: if pending, go to FETCH; clear tbl_addr, err_count, verify_err and init_done; set init_busy. Otherwise, if host_req, go to HOST. A pending run wins over a simultaneous host_req.
  - FETCH: wait one tick for ROM data.
  - DECODE:
    - tbl_data==16'hFFFF: go to DONE (end marker).
    - sub_addr==8'hFF, data!=8'hFF: go to DELAY, loading data*DELAY_UNIT ticks; data=0 means zero wait.
    - Otherwise: go to WR.
  - WR: drive sccb_id_addr=DEV_ID, sccb_rw=0, sub/data from the entry, and sccb_start=1. Hold until sccb_done is seen on a tick, then drop start.
    - If VERIFY and sub_addr!=RESET_REG, go to RD.
    - Otherwise go to NEXT.
  - RD: drive id=DEV_ID|1, rw=1, same sub_addr, start=1 until done. Compare sccb_data_out with the entry data. On mismatch: verify_err=1, err_count+1 (saturates at 255). Then go to NEXT.
  - DELAY: decrement each tick; go to NEXT at 0.
  - NEXT: if tbl_addr is all-ones, go to DONE. Otherwise increment tbl_addr and go to FETCH.
  - DONE: init_busy=0, init_done=1, then go to IDLE.
  - HOST: latch host_rw, host_sub_addr and host_wdata at entry. Run one transaction: id=DEV_ID|host_rw. On completion, pulse host_ack; host_rdata=sccb_data_out for reads, 0 for writes. Then return to IDLE. The host must drop host_req before the next tick or it is served again.
- Timeout: a counter increments on ticks while sccb_start=1. When it reaches TIMEOUT:
  - Drop start.
  - In a table run: verify_err=1, err_count+1; a timed-out write skips its read-back; go to NEXT.
  - In HOST: host_ack with host_err=1.
- sccb_start is deasserted for at least one tick between consecutive transactions.
- host_req during a table run is held off until after DONE; it is never dropped.

Test Plan:
1. AUTO_START=1; table {1280},{FF01},{1101},{FFFF}; model echoes writes. Required: write 0x12 with no read; exactly 100 idle ticks; write 0x11 id 0x42, then read 0x11 id 0x43; init_done=1, err_count=0.
2. Same table, model returns 0x00 on read of 0x11. Required: verify_err=1, err_count=1, init_done=1.
3. Model never asserts sccb_done on the first write. Required: start drops after 1000 ticks, err_count=1, sequence completes through the end marker.
4. host_req (read 0x0A) asserted during the delay entry. Required: no host transaction before init_done; then one read id 0x43 sub 0x0A; single-PCLK host_ack with host_rdata=0x76, host_err=0.
5. PRESETN low during WR with sccb_start=1. Required: sccb_start=0 and all outputs 0 immediately; after release, the run restarts from tbl_addr=0.
6. start_init pulse between ticks, with host_req asserted in IDLE on the same tick. Required: pulse captured; table run starts first; host is served after DONE.
